// File: rtl/rs232_rx_fifo.sv
// rs232_rx_fifo
//   Parametrised asynchronous serial receiver with a small character FIFO.
//   Each received character is written to the FIFO together with its parity
//   and framing error flags. The processor reads the character at the head of
//   the FIFO.
//
//   Parameters
//     CLKDIV   clk cycles per bit, >= 8
//     DBITS    data bits per character, 5..8, LSB first
//     PARITY   0 none, 1 odd, 2 even
//     STOPB    number of stop bits checked, 1 or 2
//     FIFOLOG  FIFO depth = 2**FIFOLOG entries, 1..4
//
//   Ports
//     clk        system clock, rising edge
//     rst        asynchronous reset, active low
//     RxD        serial line, idle high, asynchronous to clk
//     done       consumer pulse: head character taken, pop
//     clrerr     pulse: clear sticky ovf
//     rdy        FIFO not empty
//     data       head character (0 when empty)
//     perr       head character parity error (0 when empty)
//     ferr       head character framing error (0 when empty)
//     ovf        sticky: a character was dropped because the FIFO was full
//     dbg_state  receive FSM state (0 IDLE, 1 START, 2 SHIFT, 3 BRK)
//
//   Handshake: rdy acts as valid and done acts as ready. The head entry
//   transfers on every rising edge where rdy=1 and done=1. The entry then
//   leaves the FIFO. If done is asserted while rdy=0, nothing happens.
module rs232_rx_fifo #(
    parameter int CLKDIV  = 1302,
    parameter int DBITS   = 8,
    parameter int PARITY  = 0,
    parameter int STOPB   = 1,
    parameter int FIFOLOG = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             RxD,
    input  logic             done,
    input  logic             clrerr,
    output logic             rdy,
    output logic [DBITS-1:0] data,
    output logic             perr,
    output logic             ferr,
    output logic             ovf,
    output logic [1:0]       dbg_state
);

    localparam int HALF  = CLKDIV / 2;
    localparam int P     = (PARITY != 0) ? 1 : 0;
    localparam int N     = DBITS + P + STOPB;
    localparam int TW    = $clog2(CLKDIV);
    localparam int CW    = $clog2(N + 1);
    localparam int DEPTH = 1 << FIFOLOG;
    localparam int EW    = DBITS + 2;

    localparam logic [TW-1:0] HALF_M1 = TW'(HALF - 1);
    localparam logic [TW-1:0] DIV_M1  = TW'(CLKDIV - 1);
    localparam logic [CW-1:0] DB_C    = CW'(DBITS);
    localparam logic [CW-1:0] LAST_C  = CW'(N - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, SHIFT = 2'd2, BRK = 2'd3} state_t;

    // ---------------- synchroniser ----------------
    logic rx_s1, rx_s2, rxs;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
        end else begin
            rx_s1 <= RxD;
            rx_s2 <= rx_s1;
        end
    end

    assign rxs = rx_s2;

    // ---------------- receive FSM ----------------
    state_t           state;
    logic [TW-1:0]    tick;
    logic [CW-1:0]    bitcnt;
    logic [DBITS-1:0] shreg;
    logic             par_acc;
    logic             ferr_acc;

    logic             is_data, is_par, is_stop, is_last;
    logic             par_nxt, ferr_nxt, perr_calc, push;
    logic [EW-1:0]    push_word;

    always_comb begin
        is_data  = (bitcnt < DB_C);
        is_par   = (P != 0) && (bitcnt == DB_C);
        is_stop  = !is_data && !is_par;
        is_last  = (bitcnt == LAST_C);
        // Error flags include the current sample, so the push on the last
        // edge stores the final values.
        par_nxt  = par_acc ^ ((is_data || is_par) ? rxs : 1'b0);
        ferr_nxt = ferr_acc | (is_stop & ~rxs);
        case (PARITY)
            1:       perr_calc = ~par_nxt;   // odd: error when ones count is even
            2:       perr_calc = par_nxt;    // even: error when ones count is odd
            default: perr_calc = 1'b0;
        endcase
        push      = (state == SHIFT) && (tick == DIV_M1) && is_last;
        push_word = {perr_calc, ferr_nxt, shreg};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            tick     <= '0;
            bitcnt   <= '0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            ferr_acc <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    tick <= '0;
                    if (!rxs) state <= START;
                end
                START: begin
                    if (tick == HALF_M1) begin
                        tick <= '0;
                        if (rxs) begin
                            state <= IDLE;         // glitch, not a real start bit
                        end else begin
                            state    <= SHIFT;
                            bitcnt   <= '0;
                            par_acc  <= 1'b0;
                            ferr_acc <= 1'b0;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                SHIFT: begin
                    if (tick == DIV_M1) begin
                        tick     <= '0;
                        par_acc  <= par_nxt;
                        ferr_acc <= ferr_nxt;
                        if (is_data) shreg <= {rxs, shreg[DBITS-1:1]};
                        if (is_last) begin
                            // A line still low after a bad stop bit is a break.
                            // Hold off start detection until the line goes high.
                            if (ferr_nxt && !rxs) state <= BRK;
                            else                  state <= IDLE;
                        end else begin
                            bitcnt <= bitcnt + 1'b1;
                        end
                    end else begin
                        tick <= tick + 1'b1;
                    end
                end
                BRK: begin
                    tick <= '0;
                    if (rxs) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign dbg_state = state;

    // ---------------- FIFO ----------------
    logic [FIFOLOG:0] wptr, rptr;
    logic [EW-1:0]    mem [DEPTH];
    logic [EW-1:0]    head;
    logic             empty, full, pop, wr_en, drop;

    always_comb begin
        empty = (wptr == rptr);
        full  = (wptr[FIFOLOG] != rptr[FIFOLOG]) &&
                (wptr[FIFOLOG-1:0] == rptr[FIFOLOG-1:0]);
        pop   = done & ~empty;
        // If the FIFO is full, a pop in the same cycle frees the slot for the push.
        wr_en = push & (~full | pop);
        drop  = push & full & ~pop;
        head  = mem[rptr[FIFOLOG-1:0]];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr <= '0;
            rptr <= '0;
            ovf  <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + 1'b1;
            if (pop)   rptr <= rptr + 1'b1;
            if (drop)        ovf <= 1'b1;
            else if (clrerr) ovf <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wptr[FIFOLOG-1:0]] <= push_word;
    end

    assign rdy  = ~empty;
    assign data = empty ? '0 : head[DBITS-1:0];
    assign ferr = ~empty & head[DBITS];
    assign perr = ~empty & head[DBITS+1];

endmodule

// File: tb/tb_rs232_rx_fifo.sv
// tb_rs232_rx_fifo
//   Directed bench for rs232_rx_fifo with CLKDIV=16. Four instances are used:
//   8N1 with a 4-deep FIFO, even parity, odd parity, and 5 data bits with
//   2 stop bits. Each instance has its own RxD and done line.
module tb_rs232_rx_fifo;

    localparam int DIV = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] rxd_v  = 4'hF;
    logic [3:0] done_v = 4'h0;
    logic       clrerr = 1'b0;

    logic [3:0] rdy_v, perr_v, ferr_v, ovf_v;
    logic [7:0] data_v [3];
    logic [4:0] data5;
    logic [1:0] st_v [4];

    rs232_rx_fifo #(.CLKDIV(DIV), .DBITS(8), .PARITY(0), .STOPB(1), .FIFOLOG(2)) u_dut (
        .clk(clk), .rst(rst), .RxD(rxd_v[0]), .done(done_v[0]), .clrerr(clrerr),
        .rdy(rdy_v[0]), .data(data_v[0]), .perr(perr_v[0]), .ferr(ferr_v[0]),
        .ovf(ovf_v[0]), .dbg_state(st_v[0]));

    rs232_rx_fifo #(.CLKDIV(DIV), .DBITS(8), .PARITY(2), .STOPB(1), .FIFOLOG(2)) u_even (
        .clk(clk), .rst(rst), .RxD(rxd_v[1]), .done(done_v[1]), .clrerr(clrerr),
        .rdy(rdy_v[1]), .data(data_v[1]), .perr(perr_v[1]), .ferr(ferr_v[1]),
        .ovf(ovf_v[1]), .dbg_state(st_v[1]));

    rs232_rx_fifo #(.CLKDIV(DIV), .DBITS(8), .PARITY(1), .STOPB(1), .FIFOLOG(2)) u_odd (
        .clk(clk), .rst(rst), .RxD(rxd_v[2]), .done(done_v[2]), .clrerr(clrerr),
        .rdy(rdy_v[2]), .data(data_v[2]), .perr(perr_v[2]), .ferr(ferr_v[2]),
        .ovf(ovf_v[2]), .dbg_state(st_v[2]));

    rs232_rx_fifo #(.CLKDIV(DIV), .DBITS(5), .PARITY(0), .STOPB(2), .FIFOLOG(1)) u_d5 (
        .clk(clk), .rst(rst), .RxD(rxd_v[3]), .done(done_v[3]), .clrerr(clrerr),
        .rdy(rdy_v[3]), .data(data5), .perr(perr_v[3]), .ferr(ferr_v[3]),
        .ovf(ovf_v[3]), .dbg_state(st_v[3]));

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_errors = 0;
    int rise_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // Frame bits LSB first: start, data, optional parity, stop bits.
    function automatic logic [15:0] mk_frame(input logic [7:0] d, input int dbits,
                                             input int par_en, input logic pbit,
                                             input int stopb);
        logic [15:0] f;
        int          idx;
        f      = '1;
        f[0]   = 1'b0;
        idx    = 1;
        for (int i = 0; i < dbits; i++) begin
            f[idx] = d[i];
            idx++;
        end
        if (par_en != 0) begin
            f[idx] = pbit;
            idx++;
        end
        for (int i = 0; i < stopb; i++) begin
            f[idx] = 1'b1;
            idx++;
        end
        return f;
    endfunction

    // Drives nbits bits of DIV cycles each on line sel, starting at a negedge.
    // rise_cyc records the first cycle (posedges since start) at which rdy is
    // seen rising.
    task automatic drive_bits(input int sel, input logic [15:0] bits, input int nbits);
        logic prev;
        prev     = rdy_v[sel];
        rise_cyc = -1;
        for (int c = 0; c < nbits * DIV; c++) begin
            rxd_v[sel] = bits[c / DIV];
            @(negedge clk);
            if (rdy_v[sel] && !prev && rise_cyc < 0) rise_cyc = c + 1;
            prev = rdy_v[sel];
        end
    endtask

    task automatic hold_line(input int sel, input logic lvl, input int cycles);
        rxd_v[sel] = lvl;
        repeat (cycles) @(negedge clk);
    endtask

    task automatic send(input int sel, input logic [7:0] d, input int dbits,
                        input int par_en, input logic pbit, input int stopb);
        drive_bits(sel, mk_frame(d, dbits, par_en, pbit, stopb), 1 + dbits + par_en + stopb);
        hold_line(sel, 1'b1, 4);
    endtask

    task automatic pop(input int sel);
        done_v[sel] = 1'b1;
        @(negedge clk);
        done_v[sel] = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [15:0] f;

        // reset state
        repeat (3) @(negedge clk);
        check("rst_rdy",   rdy_v[0], 0);
        check("rst_data",  data_v[0], 0);
        check("rst_perr",  perr_v[0], 0);
        check("rst_ferr",  ferr_v[0], 0);
        check("rst_ovf",   ovf_v[0], 0);
        check("rst_state", st_v[0], 0);
        rst = 1'b1;
        repeat (4) @(negedge clk);

        // 1: 8N1 0xA5. The 2-flop synchroniser puts t0 at the 3rd edge, so
        // rdy rises 3+8+9*16 = 155 edges after the start bit is driven.
        drive_bits(0, mk_frame(8'hA5, 8, 0, 1'b0, 1), 10);
        check("t1_rise", rise_cyc, 155);
        check("t1_data", data_v[0], 8'hA5);
        check("t1_perr", perr_v[0], 0);
        check("t1_ferr", ferr_v[0], 0);
        pop(0);
        check("t1_rdy_after", rdy_v[0], 0);
        check("t1_data_after", data_v[0], 0);

        // 2: parity. 0x07 has three ones.
        send(1, 8'h07, 8, 1, 1'b0, 1);
        check("t2_even_p0_data", data_v[1], 8'h07);
        check("t2_even_p0_perr", perr_v[1], 1);
        pop(1);
        send(1, 8'h07, 8, 1, 1'b1, 1);
        check("t2_even_p1_perr", perr_v[1], 0);
        check("t2_even_p1_ferr", ferr_v[1], 0);
        pop(1);
        send(2, 8'h07, 8, 1, 1'b0, 1);
        check("t2_odd_p0_perr", perr_v[2], 0);
        pop(2);
        send(2, 8'h07, 8, 1, 1'b1, 1);
        check("t2_odd_p1_perr", perr_v[2], 1);
        pop(2);
        check("t2_odd_empty", rdy_v[2], 0);

        // 3: 0x3C with a stop bit that stays low for 40 bit times
        f = mk_frame(8'h3C, 8, 0, 1'b0, 1);
        drive_bits(0, f, 9);
        hold_line(0, 1'b0, 40 * DIV);
        check("t3_state_brk", st_v[0], 3);
        check("t3_rdy", rdy_v[0], 1);
        check("t3_data", data_v[0], 8'h3C);
        check("t3_ferr", ferr_v[0], 1);
        pop(0);
        check("t3_single_entry", rdy_v[0], 0);
        hold_line(0, 1'b1, 40);
        check("t3_state_idle", st_v[0], 0);
        send(0, 8'h55, 8, 0, 1'b0, 1);
        check("t3_next_data", data_v[0], 8'h55);
        check("t3_next_ferr", ferr_v[0], 0);
        pop(0);

        // 4: low glitch of 5 cycles
        hold_line(0, 1'b0, 4);
        check("t4_state_start", st_v[0], 1);
        hold_line(0, 1'b0, 1);
        hold_line(0, 1'b1, 40);
        check("t4_state_idle", st_v[0], 0);
        check("t4_rdy", rdy_v[0], 0);

        // 5: overflow with a 4-deep FIFO
        for (int i = 1; i <= 5; i++) send(0, 8'(i), 8, 0, 1'b0, 1);
        check("t5_ovf_set", ovf_v[0], 1);
        for (int i = 1; i <= 4; i++) begin
            check($sformatf("t5_pop%0d_rdy", i), rdy_v[0], 1);
            check($sformatf("t5_pop%0d_data", i), data_v[0], i);
            pop(0);
        end
        check("t5_empty", rdy_v[0], 0);
        check("t5_ovf_sticky", ovf_v[0], 1);
        clrerr = 1'b1;
        @(negedge clk);
        clrerr = 1'b0;
        check("t5_ovf_clr", ovf_v[0], 0);
        pop(0);
        check("t5_done_empty_rdy", rdy_v[0], 0);
        check("t5_done_empty_data", data_v[0], 0);
        send(0, 8'h66, 8, 0, 1'b0, 1);
        check("t5_after_data", data_v[0], 8'h66);
        pop(0);
        check("t5_after_empty", rdy_v[0], 0);

        // 6: reset during data bit 3 of 0x81, with 0x11 already buffered
        send(0, 8'h11, 8, 0, 1'b0, 1);
        drive_bits(0, mk_frame(8'h81, 8, 0, 1'b0, 1), 5);
        check("t6_pre_state", st_v[0], 2);
        check("t6_pre_rdy", rdy_v[0], 1);
        rst = 1'b0;
        rxd_v[0] = 1'b1;
        #1;
        check("t6_rst_rdy", rdy_v[0], 0);
        check("t6_rst_data", data_v[0], 0);
        check("t6_rst_state", st_v[0], 0);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        send(0, 8'h42, 8, 0, 1'b0, 1);
        check("t6_42_data", data_v[0], 8'h42);
        check("t6_42_ferr", ferr_v[0], 0);
        pop(0);

        // DBITS=5, STOPB=2
        send(3, 8'h15, 5, 0, 1'b0, 2);
        check("t6_d5_data", data5, 5'h15);
        check("t6_d5_ferr", ferr_v[3], 0);
        check("t6_d5_perr", perr_v[3], 0);
        pop(3);
        f = mk_frame(8'h0A, 5, 0, 1'b0, 2);
        f[7] = 1'b0;   // second stop bit bad
        drive_bits(3, f, 8);
        hold_line(3, 1'b1, 8);
        check("t6_d5_stop2_data", data5, 5'h0A);
        check("t6_d5_stop2_ferr", ferr_v[3], 1);
        check("t6_d5_state", st_v[3], 0);
        pop(3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
